// File: rtl/vector_add_stream.sv
// vector_add_stream: LANES x fp32 lane-wise add/sub stream, credit-gated input, token tracking, FWFT output FIFO.
// Define VADD_PERF_CNT_EN to add perf_in_cnt / perf_out_cnt / perf_stall_cnt counter outputs.

// Behavioural stand-in for the vendor fp32 adder IP: fixed LATENCY, no stall, no reset, RNE rounding.
module floating_point_add #(
   parameter int unsigned LATENCY = 11
) (
   input  logic        aclk,
   input  logic [31:0] s_axis_a_tdata,
   input  logic [31:0] s_axis_b_tdata,
   output logic [31:0] m_axis_result_tdata
);
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y, res, d;
      logic [9:0]  ex, ey, e;
      logic [27:0] mx, my, r;
      logic [24:0] m;
      if (a[30:0] >= b[30:0]) begin x = a; y = b; end
      else                    begin x = b; y = a; end
      ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b0, x[30:23]};
      ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b0, y[30:23]};
      mx = {1'b0, x[30:23] != 8'd0, x[22:0], 3'b0};
      my = {1'b0, y[30:23] != 8'd0, y[22:0], 3'b0};
      d  = {22'b0, ex - ey};
      // Alignment keeps shifted-out bits ORed into bit 0 as sticky.
      for (int unsigned i = 0; i < 27; i++)
         if (i < d) my = {1'b0, my[27:2], my[1] | my[0]};
      r = (x[31] == y[31]) ? mx + my : mx - my;
      e = ex;
      if (r[27]) begin
         r = {1'b0, r[27:2], r[1] | r[0]};
         e = e + 10'd1;
      end else begin
         for (int unsigned i = 0; i < 26; i++)
            if (!r[26] && e > 10'd1) begin
               r = r << 1;
               e = e - 10'd1;
            end
      end
      m = {1'b0, r[26:3]} + {24'b0, r[2] & (r[1] | r[0] | r[3])};
      if (m[24]) begin
         m = {1'b0, m[24:1]};
         e = e + 10'd1;
      end
      if (x[30:23] == 8'hFF) begin
         if (x[22:0] != 23'd0)                          res = 32'h7FC0_0000;
         else if (y[30:23] == 8'hFF && y[31] != x[31]) res = 32'h7FC0_0000;
         else                                           res = x;
      end else if (r == 28'd0) begin
         res = {(x[31] == y[31]) ? x[31] : 1'b0, 31'd0};
      end else if (e >= 10'd255) begin
         res = {x[31], 8'hFF, 23'd0};
      end else begin
         res = {x[31], m[23] ? e[7:0] : 8'd0, m[22:0]};
      end
      return res;
   endfunction

   logic [31:0] r_pipe [LATENCY];

   always_ff @(posedge aclk) begin
      r_pipe[0] <= fadd(s_axis_a_tdata, s_axis_b_tdata);
      for (int unsigned i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
   end

   assign m_axis_result_tdata = r_pipe[LATENCY-1];
endmodule

module vector_add_stream #(
   parameter int unsigned LANES      = 16,
   parameter int unsigned ADD_LAT    = 11,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [32*LANES-1:0] in_a,
   input  logic [32*LANES-1:0] in_b,
   input  logic                in_sub,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*LANES-1:0] out_data,
   output logic                out_last
`ifdef VADD_PERF_CNT_EN
  ,output logic [31:0]         perf_in_cnt,
   output logic [31:0]         perf_out_cnt,
   output logic [31:0]         perf_stall_cnt
`endif
);
   localparam int unsigned W  = 32*LANES;
   localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [W-1:0]       w_b_ip, w_res;
   logic [W:0]         w_head;
   logic [CW:0]        w_used;
   logic               w_accept, w_push, w_pop;
   logic [ADD_LAT-1:0] r_tok_vld, r_tok_last;
   logic [CW-1:0]      r_inflight, r_count;
   logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
   logic [W:0]         r_mem [FIFO_DEPTH];

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_b_ip[32*g +: 32] = {in_b[32*g+31] ^ in_sub, in_b[32*g +: 31]};
      floating_point_add #(.LATENCY(ADD_LAT)) u_add (
         .aclk                (clk),
         .s_axis_a_tdata      (in_a[32*g +: 32]),
         .s_axis_b_tdata      (w_b_ip[32*g +: 32]),
         .m_axis_result_tdata (w_res[32*g +: 32])
      );
   end

   // Credit covers every beat that could still land in the FIFO.
   assign w_used    = {1'b0, r_inflight} + {1'b0, r_count};
   assign in_ready  = !rst && (w_used < (CW+1)'(FIFO_DEPTH));
   assign w_accept  = in_valid && in_ready;
   assign w_push    = r_tok_vld[ADD_LAT-1];
   assign out_valid = !rst && (r_count != '0);
   assign w_pop     = out_valid && out_ready;
   assign w_head    = r_mem[r_rd_ptr];
   assign out_data  = out_valid ? w_head[W-1:0] : '0;
   assign out_last  = out_valid && w_head[W];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tok_vld  <= '0;
         r_tok_last <= '0;
         r_inflight <= '0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_tok_vld  <= {r_tok_vld[ADD_LAT-2:0], w_accept};
         r_tok_last <= {r_tok_last[ADD_LAT-2:0], in_last & w_accept};
         case ({w_accept, w_push})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {r_tok_last[ADD_LAT-1], w_res};
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(w_push && !w_pop && r_count == CW'(FIFO_DEPTH)));
   end

`ifdef VADD_PERF_CNT_EN
   logic [31:0] r_perf_in, r_perf_out, r_perf_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_in    <= '0;
         r_perf_out   <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_accept)              r_perf_in    <= r_perf_in + 32'd1;
         if (w_pop)                 r_perf_out   <= r_perf_out + 32'd1;
         if (out_valid && !out_ready) r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_in_cnt    = r_perf_in;
   assign perf_out_cnt   = r_perf_out;
   assign perf_stall_cnt = r_perf_stall;
`endif
endmodule

// File: tb/tb_vector_add_stream.sv
// Directed bench for vector_add_stream: latency, add/sub, streaming order, backpressure, mid-flight reset.
// With VADD_PERF_CNT_EN defined the performance counters are also checked after the backpressure run.
module tb_vector_add_stream;
   localparam int unsigned LANES      = 16;
   localparam int unsigned ADD_LAT    = 11;
   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned W          = 32*LANES;

   logic         clk = 1'b0, rst = 1'b1;
   logic         in_valid = 1'b0, in_sub = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic         in_ready, out_valid, out_last;
   logic [W-1:0] out_data;
`ifdef VADD_PERF_CNT_EN
   logic [31:0]  perf_in_cnt, perf_out_cnt, perf_stall_cnt;
`endif

   int unsigned  n_chk = 0, n_err = 0, cyc = 0, stab_err = 0;
   logic [W-1:0] out_q [$];
   logic         last_q [$];
   int unsigned  ocyc_q [$];
   logic         hold_pend = 1'b0, hold_last = 1'b0;
   logic [W-1:0] hold_data = '0;

   vector_add_stream #(.LANES(LANES), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef VADD_PERF_CNT_EN
     ,.perf_in_cnt(perf_in_cnt), .perf_out_cnt(perf_out_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before finish");
      $fatal;
   end

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         out_q.push_back(out_data);
         last_q.push_back(out_last);
         ocyc_q.push_back(cyc);
      end
      if (hold_pend && !rst && !(out_valid && out_data == hold_data && out_last == hold_last))
         stab_err++;
      hold_pend = out_valid && !out_ready && !rst;
      hold_data = out_data;
      hold_last = out_last;
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] i2f(input int unsigned n);
      logic [31:0] nn, m;
      int unsigned p;
      nn = n;
      p  = 0;
      if (n == 0) return '0;
      for (int unsigned j = 0; j < 24; j++) if (nn[j]) p = j;
      m = nn << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   function automatic logic [W-1:0] splat(input logic [31:0] v);
      return {LANES{v}};
   endfunction

   function automatic logic [W-1:0] ramp();
      logic [W-1:0] r;
      for (int unsigned i = 0; i < LANES; i++) r[32*i +: 32] = i2f(i);
      return r;
   endfunction

   function automatic logic [W-1:0] sum_vec(input int unsigned k);
      logic [W-1:0] r;
      for (int unsigned i = 0; i < LANES; i++) r[32*i +: 32] = i2f(k + i);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      out_q.delete();
      last_q.delete();
      ocyc_q.delete();
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic last,
                       output int unsigned acc_cyc);
      logic done;
      done    = 1'b0;
      acc_cyc = 0;
      in_a = a; in_b = b; in_sub = sub; in_last = last; in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            done    = 1'b1;
            acc_cyc = cyc;
         end
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("send_accepted", done, 1);
   endtask

   task automatic wait_out(input string tag, input int unsigned n, input int unsigned budget);
      for (int unsigned i = 0; i < budget && out_q.size() < n; i++) tick();
      check(tag, out_q.size(), n);
   endtask

   int unsigned t, acc, stalls;
   int unsigned acc_c [$];
   logic        rdy_last;

   initial begin
      // reset state
      rst = 1'b1;
      tick(); tick();
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, '0);
      check("rst_out_last", out_last, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      tick();

      // 1.0 + 2.0
      clear_q();
      send(splat(32'h3F80_0000), splat(32'h4000_0000), 1'b0, 1'b0, t);
      wait_out("t1_count", 1, 40);
      check("t1_latency", ocyc_q[0] - t, ADD_LAT + 1);
      check("t1_data", out_q[0], splat(32'h4040_0000));
      check("t1_last", last_q[0], 0);

      // 3.0 - 1.0 with last
      clear_q();
      send(splat(32'h4040_0000), splat(32'h3F80_0000), 1'b1, 1'b1, t);
      wait_out("t2_count", 1, 40);
      check("t2_data", out_q[0], splat(32'h4000_0000));
      check("t2_last", last_q[0], 1);

      // 100 back-to-back beats
      clear_q();
      acc_c.delete();
      for (int unsigned k = 0; k < 100; k++) begin
         send(splat(i2f(k)), ramp(), 1'b0, 1'b0, t);
         acc_c.push_back(t);
      end
      check("t3_accept_span", acc_c[99] - acc_c[0], 99);
      wait_out("t3_count", 100, 60);
      check("t3_first_latency", ocyc_q[0] - acc_c[0], ADD_LAT + 1);
      check("t3_out_span", ocyc_q[99] - ocyc_q[0], 99);
      for (int unsigned k = 0; k < 100; k++) check($sformatf("t3_data[%0d]", k), out_q[k], sum_vec(k));

      // backpressure: fill credit, hold 20 stall cycles, then drain
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      clear_q();
      out_ready = 1'b0;
      acc = 0; stalls = 0; rdy_last = 1'b1;
      in_a = splat(i2f(200)); in_b = ramp(); in_sub = 1'b0; in_last = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 100 && stalls < 20; c++) begin
         @(negedge clk);
         rdy_last = in_ready;
         if (in_ready) acc++;
         if (out_valid) stalls++;
         tick();
         in_a    = splat(i2f(200 + acc));
         in_last = acc[0];
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("t4_accepted", acc, FIFO_DEPTH);
      check("t4_in_ready_low", rdy_last, 0);
      check("t4_no_pop_while_stalled", out_q.size(), 0);
      out_ready = 1'b1;
      wait_out("t4_count", FIFO_DEPTH, 60);
      repeat (20) tick();
      check("t4_no_extra", out_q.size(), FIFO_DEPTH);
      for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
         check($sformatf("t4_data[%0d]", j), out_q[j], sum_vec(200 + j));
         check($sformatf("t4_last[%0d]", j), last_q[j], j % 2);
      end
`ifdef VADD_PERF_CNT_EN
      check("perf_in_cnt", perf_in_cnt, FIFO_DEPTH);
      check("perf_out_cnt", perf_out_cnt, FIFO_DEPTH);
      check("perf_stall_cnt", perf_stall_cnt, 20);
`endif

      // reset while 5 beats are in flight
      clear_q();
      for (int unsigned k = 0; k < 5; k++) send(splat(i2f(50 + k)), ramp(), 1'b0, 1'b1, t);
      tick(); tick();
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_in_ready", in_ready, 0);
      check("t5_rst_out_valid", out_valid, 0);
      tick();
      rst = 1'b0;
      send(splat(i2f(7)), splat(i2f(5)), 1'b1, 1'b0, t);
      repeat (40) tick();
      check("t5_count", out_q.size(), 1);
      check("t5_latency", ocyc_q[0] - t, ADD_LAT + 1);
      check("t5_data", out_q[0], splat(32'h4000_0000));
      check("t5_last", last_q[0], 0);

      check("hold_stable", stab_err, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
